tb_stream_checker: RTL and testbench

- Synthesisable self-checking stage that sits downstream of each unit test bench and consumes the DUT output stream.
- The bench pushes expected words into a small in-order queue. The checker compares each observed DUT word against the queue head and counts mismatches.
- It flags pass/fail/timeout in hardware, mirroring the bench-level "all asserts ok" flag and timeout.
- It lets long processor runs be checked cycle-accurately without per-sample bench assertions.

---
 rtl/tb_stream_checker.sv | 123 ++++++++++++
 tb/tb_tb_stream_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tb_stream_checker.sv
// In-order expected-vs-observed stream checker with hardware pass/fail/timeout flags.
// Expected words queue up; each DUT output sample pops and compares against the head.
module tb_stream_checker #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   EXP_VALID,
    input  logic [WIDTH-1:0]       EXP_DATA,
    input  logic                   EXP_LAST,
    output logic                   EXP_READY,
    input  logic                   OBS_VALID,
    input  logic [WIDTH-1:0]       OBS_DATA,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   PASS,
    output logic                   TIMED_OUT,
    output logic [COUNT_WIDTH-1:0] ERR_COUNT,
    output logic [COUNT_WIDTH-1:0] CHECK_COUNT,
    output logic [COUNT_WIDTH-1:0] FIRST_ERR_INDEX
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH:0]         mem_q [DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [CW-1:0]          cnt_q;
    logic [TW-1:0]          timer_q;
    logic                   last_seen_q;
    logic                   timed_out_q;
    logic [COUNT_WIDTH-1:0] err_q, chk_q, first_q;

    logic run, full, empty, push, obs, pop, underflow, err;
    logic last_pop, timeout;
    logic [WIDTH:0] head;

    assign run       = (state_q == S_RUN);
    assign full      = cnt_q[AW];
    assign empty     = (cnt_q == '0);
    assign head      = mem_q[rd_q];
    assign push      = EXP_VALID && EXP_READY;
    assign obs       = run && OBS_VALID;
    assign pop       = obs && !empty;
    assign underflow = obs && empty;
    assign err       = underflow || (pop && (head[WIDTH-1:0] != OBS_DATA));
    assign last_pop  = pop && head[WIDTH];
    // A final-word pop wins over a coincident timeout so a clean finish is not misreported.
    assign timeout   = run && (timer_q == TMAX) && !last_pop;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (START) begin
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_RUN:   if (last_pop || timeout) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        BUSY            = run;
        DONE            = (state_q == S_DONE);
        EXP_READY       = run && !full && !last_seen_q;
        TIMED_OUT       = timed_out_q;
        PASS            = DONE && !timed_out_q && (err_q == '0);
        ERR_COUNT       = err_q;
        CHECK_COUNT     = chk_q;
        FIRST_ERR_INDEX = first_q;
    end

    always_ff @(posedge CLK) begin
        if (push && !START) mem_q[wr_q] <= {EXP_LAST, EXP_DATA};
    end

    always_ff @(posedge CLK) begin
        if (RST || START) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            last_seen_q <= 1'b0;
            timed_out_q <= 1'b0;
            err_q       <= '0;
            chk_q       <= '0;
            first_q     <= '0;
        end else if (run) begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
                if (EXP_LAST) last_seen_q <= 1'b1;
            end
            if (pop) rd_q <= rd_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
            if (obs) chk_q <= chk_q + COUNT_WIDTH'(1);
            if (err) begin
                if (err_q != '1) err_q <= err_q + COUNT_WIDTH'(1);
                if (err_q == '0) first_q <= chk_q;
            end
            if (push || obs)        timer_q <= '0;
            else if (timer_q != TMAX) timer_q <= timer_q + TW'(1);
            if (timeout) timed_out_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tb_stream_checker.sv
// Directed bench for tb_stream_checker: clean run, mismatch, backpressure,
// same-cycle underflow, inactivity timeout and mid-run reset.
module tb_tb_stream_checker;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        EXP_VALID = 1'b0;
    logic [7:0]  EXP_DATA = '0;
    logic        EXP_LAST = 1'b0;
    logic        EXP_READY;
    logic        OBS_VALID = 1'b0;
    logic [7:0]  OBS_DATA = '0;
    logic        BUSY, DONE, PASS, TIMED_OUT;
    logic [15:0] ERR_COUNT, CHECK_COUNT, FIRST_ERR_INDEX;

    int total = 0;
    int bad   = 0;

    tb_stream_checker #(
        .WIDTH(8), .DEPTH(4), .TIMEOUT_CYCLES(8), .COUNT_WIDTH(16)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .EXP_VALID(EXP_VALID), .EXP_DATA(EXP_DATA), .EXP_LAST(EXP_LAST),
        .EXP_READY(EXP_READY),
        .OBS_VALID(OBS_VALID), .OBS_DATA(OBS_DATA),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMED_OUT(TIMED_OUT),
        .ERR_COUNT(ERR_COUNT), .CHECK_COUNT(CHECK_COUNT),
        .FIRST_ERR_INDEX(FIRST_ERR_INDEX)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        EXP_VALID = 1'b1;
        EXP_DATA  = d;
        EXP_LAST  = last;
        step();
        EXP_VALID = 1'b0;
        EXP_LAST  = 1'b0;
    endtask

    task automatic observe(input logic [7:0] d);
        OBS_VALID = 1'b1;
        OBS_DATA  = d;
        step();
        OBS_VALID = 1'b0;
    endtask

    task automatic start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_pass", PASS, 0);
        chk("rst_rdy", EXP_READY, 0);
        chk("rst_err", ERR_COUNT, 0);
        chk("rst_chk", CHECK_COUNT, 0);

        // clean run
        start();
        chk("t1_busy", BUSY, 1);
        chk("t1_rdy", EXP_READY, 1);
        push(8'h11, 0);
        push(8'h22, 0);
        push(8'h33, 1);
        chk("t1_rdy_last", EXP_READY, 0);
        observe(8'h11);
        observe(8'h22);
        chk("t1_notdone", DONE, 0);
        observe(8'h33);
        chk("t1_done", DONE, 1);
        chk("t1_pass", PASS, 1);
        chk("t1_err", ERR_COUNT, 0);
        chk("t1_chk", CHECK_COUNT, 3);
        chk("t1_first", FIRST_ERR_INDEX, 0);
        chk("t1_busy0", BUSY, 0);
        observe(8'hEE);
        chk("t1_hold_chk", CHECK_COUNT, 3);
        chk("t1_hold_pass", PASS, 1);

        // mismatch
        start();
        chk("t2_clr_chk", CHECK_COUNT, 0);
        chk("t2_clr_done", DONE, 0);
        push(8'hA0, 0);
        push(8'hA1, 0);
        push(8'hA2, 1);
        observe(8'hA0);
        observe(8'hFF);
        observe(8'hA2);
        chk("t2_done", DONE, 1);
        chk("t2_pass", PASS, 0);
        chk("t2_err", ERR_COUNT, 1);
        chk("t2_first", FIRST_ERR_INDEX, 1);
        chk("t2_chk", CHECK_COUNT, 3);

        // backpressure
        start();
        for (int i = 1; i <= 4; i++) begin
            chk("t3_rdy", EXP_READY, 1);
            push(8'(i), 0);
        end
        chk("t3_full", EXP_READY, 0);
        EXP_VALID = 1'b1;
        EXP_DATA  = 8'h05;
        step();
        chk("t3_held", EXP_READY, 0);
        OBS_VALID = 1'b1;
        OBS_DATA  = 8'h01;
        chk("t3_pop_rdy", EXP_READY, 0);
        step();
        OBS_VALID = 1'b0;
        chk("t3_freed", EXP_READY, 1);
        step();
        EXP_VALID = 1'b0;
        chk("t3_refull", EXP_READY, 0);
        for (int i = 2; i <= 5; i++) observe(8'(i));
        chk("t3_err", ERR_COUNT, 0);
        chk("t3_chk", CHECK_COUNT, 5);
        chk("t3_busy", BUSY, 1);

        // same-cycle push + observe on empty queue
        start();
        chk("t4_clr_chk", CHECK_COUNT, 0);
        EXP_VALID = 1'b1;
        EXP_DATA  = 8'h55;
        EXP_LAST  = 1'b1;
        OBS_VALID = 1'b1;
        OBS_DATA  = 8'h55;
        step();
        EXP_VALID = 1'b0;
        EXP_LAST  = 1'b0;
        OBS_VALID = 1'b0;
        chk("t4_uf_err", ERR_COUNT, 1);
        chk("t4_uf_first", FIRST_ERR_INDEX, 0);
        chk("t4_uf_done", DONE, 0);
        observe(8'h55);
        chk("t4_err", ERR_COUNT, 1);
        chk("t4_done", DONE, 1);
        chk("t4_pass", PASS, 0);
        chk("t4_chk", CHECK_COUNT, 2);

        // inactivity timeout
        start();
        push(8'h77, 0);
        for (int i = 0; i < 7; i++) step();
        chk("t5_early", DONE, 0);
        step();
        step();
        chk("t5_done", DONE, 1);
        chk("t5_to", TIMED_OUT, 1);
        chk("t5_pass", PASS, 0);
        start();
        chk("t5_busy", BUSY, 1);
        chk("t5_clr_to", TIMED_OUT, 0);
        chk("t5_clr_done", DONE, 0);
        chk("t5_clr_chk", CHECK_COUNT, 0);

        // reset mid-run
        push(8'h01, 0);
        push(8'h02, 0);
        observe(8'h01);
        chk("t6_pre_chk", CHECK_COUNT, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("t6_busy", BUSY, 0);
        chk("t6_rdy", EXP_READY, 0);
        chk("t6_chk", CHECK_COUNT, 0);
        observe(8'h99);
        observe(8'h98);
        chk("t6_ign_chk", CHECK_COUNT, 0);
        chk("t6_ign_err", ERR_COUNT, 0);
        start();
        push(8'h09, 1);
        observe(8'h09);
        chk("t6_done", DONE, 1);
        chk("t6_pass", PASS, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
